// File: rtl/vector_core_pkg.sv
// Shared vector-core sizing and the store serializer state encoding.
// Store buffer depth derives from VLMAX over the lane count.
package vector_core_pkg;

  localparam int VLEN_BITS      = 32768;
  localparam int DEF_V_LANE_NUM = 8;
  localparam int VLMAX32        = VLEN_BITS / 32;
  localparam int VLMAX32_PVL    = VLMAX32 / DEF_V_LANE_NUM;
  localparam int DEF_BUFF_DEPTH = VLMAX32_PVL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ser_state_t;

endpackage

// File: rtl/store_serializer_row_fifo.sv
// Two-entry row FIFO with registered occupancy.
// Push and pop in the same cycle both take effect.
module row_fifo #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (do_pop) begin
        rp <= ~rp;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/store_serializer.sv
// Streams lane-interleaved store-buffer rows out as 32-bit AXI-stream words.
// Rows are prefetched into a 2-entry FIFO; a lane counter picks the word.
module store_serializer
  import vector_core_pkg::*;
#(
  parameter int V_LANE_NUM         = DEF_V_LANE_NUM,
  parameter int BUFF_DEPTH         = DEF_BUFF_DEPTH,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [C_XFER_SIZE_WIDTH-1:0]             xfer_words,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     buff_rd_en,
  output logic [$clog2(BUFF_DEPTH)-1:0]            buff_rd_addr,
  input  logic [C_M_AXI_DATA_WIDTH*V_LANE_NUM-1:0] buff_rdata,
  output logic                                     rd_tvalid,
  input  logic                                     rd_tready,
  output logic                                     rd_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0]            rd_tdata
);

  localparam int AW   = $clog2(BUFF_DEPTH);
  localparam int LW   = (V_LANE_NUM > 1) ? $clog2(V_LANE_NUM) : 1;
  localparam int DW   = C_M_AXI_DATA_WIDTH;
  localparam int MAXW = BUFF_DEPTH * V_LANE_NUM;
  localparam int CW   = $clog2(MAXW) + 1;

  ser_state_t state_q;
  ser_state_t state_d;

  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] last_row_q;
  logic [LW-1:0] last_lane_q;
  logic [AW-1:0] out_row_q;
  logic [LW-1:0] lane_q;
  logic          v1_q;
  logic          v2_q;
  logic          done_q;

  logic [CW-1:0] words_c;
  logic [CW-1:0] last_idx;
  logic [AW-1:0] last_row_c;
  logic [LW-1:0] last_lane_c;
  logic          zero;
  logic          accept;
  logic [2:0]    pend;
  logic          room;
  logic          hs;
  logic          pop;
  logic [1:0]    fcount;

  logic [V_LANE_NUM*DW-1:0]         head;
  logic [V_LANE_NUM-1:0][DW-1:0]    head_lanes;

  // Oversized requests are clamped to the full buffer.
  always_comb begin
    words_c = CW'(MAXW);
    if (xfer_words < C_XFER_SIZE_WIDTH'(MAXW)) begin
      words_c = CW'(xfer_words);
    end
    last_idx    = words_c - CW'(1);
    last_row_c  = AW'(last_idx / CW'(V_LANE_NUM));
    last_lane_c = LW'(last_idx % CW'(V_LANE_NUM));
  end

  assign zero   = (xfer_words == '0);
  assign accept = start && (state_q == IDLE) && !rst;
  assign busy   = (state_q != IDLE) || accept;
  assign done   = done_q;

  // In-flight reads reserve a FIFO slot until they land.
  assign pend = 3'(fcount) + 3'(v1_q) + 3'(v2_q);
  assign room = (pend < 3'd2);

  assign head_lanes = head;
  assign rd_tvalid  = (fcount != 2'd0) && (state_q != IDLE);
  assign rd_tdata   = head_lanes[lane_q];
  assign rd_tlast   = rd_tvalid
                   && (out_row_q == last_row_q)
                   && (lane_q == last_lane_q);

  assign hs  = rd_tvalid && rd_tready;
  assign pop = hs && ((lane_q == LW'(V_LANE_NUM - 1)) || rd_tlast);

  row_fifo #(
    .W (V_LANE_NUM * DW)
  ) u_row_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2_q),
    .wdata (buff_rdata),
    .pop   (pop),
    .head  (head),
    .count (fcount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row 0 is fetched in the start cycle itself.
  always_comb begin
    state_d      = state_q;
    buff_rd_en   = 1'b0;
    buff_rd_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && !zero) begin
          buff_rd_en = 1'b1;
          state_d    = (last_row_c == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (room) begin
          buff_rd_en   = 1'b1;
          buff_rd_addr = rd_addr_q;
          if (rd_addr_q == last_row_q) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (hs && rd_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q   <= '0;
      last_row_q  <= '0;
      last_lane_q <= '0;
      out_row_q   <= '0;
      lane_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      v1_q   <= buff_rd_en;
      v2_q   <= v1_q;
      done_q <= (accept && zero) || (hs && rd_tlast);
      if (accept) begin
        last_row_q  <= last_row_c;
        last_lane_q <= last_lane_c;
        rd_addr_q   <= AW'(1);
        out_row_q   <= '0;
        lane_q      <= '0;
      end else begin
        if ((state_q == RUN) && buff_rd_en) begin
          rd_addr_q <= rd_addr_q + AW'(1);
        end
        if (pop) begin
          lane_q    <= '0;
          out_row_q <= out_row_q + AW'(1);
        end else if (hs) begin
          lane_q <= lane_q + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_store_serializer.sv
// Directed bench for store_serializer with a 2-cycle store-buffer model.
// Table vectors plus hand sequences for restart and reset corners.
module tb_store_serializer;

  localparam int L  = 8;
  localparam int D  = 128;
  localparam int AW = 7;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [31:0]         xfer_words;
  logic                busy;
  logic                done;
  logic                buff_rd_en;
  logic [AW-1:0]       buff_rd_addr;
  logic [32*L-1:0]     buff_rdata;
  logic                rd_tvalid;
  logic                rd_tready;
  logic                rd_tlast;
  logic [31:0]         rd_tdata;

  always #5 clk = ~clk;

  store_serializer #(
    .V_LANE_NUM         (L),
    .BUFF_DEPTH         (D),
    .C_M_AXI_DATA_WIDTH (32),
    .C_XFER_SIZE_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .xfer_words   (xfer_words),
    .busy         (busy),
    .done         (done),
    .buff_rd_en   (buff_rd_en),
    .buff_rd_addr (buff_rd_addr),
    .buff_rdata   (buff_rdata),
    .rd_tvalid    (rd_tvalid),
    .rd_tready    (rd_tready),
    .rd_tlast     (rd_tlast),
    .rd_tdata     (rd_tdata)
  );

  // Store buffer model: lane l of row r holds {r,l}, 2 cycles after rd_en.
  logic          req_v = 1'b0;
  logic [AW-1:0] req_a = '0;
  logic          p1_v  = 1'b0;
  logic          p2_v  = 1'b0;
  logic [AW-1:0] p1_a  = '0;
  logic [AW-1:0] p2_a  = '0;
  logic [L-1:0][31:0] bd;

  always @(negedge clk) begin
    #2;
    req_v = buff_rd_en;
    req_a = buff_rd_addr;
  end

  always @(posedge clk) begin
    p1_v <= req_v;
    p1_a <= req_a;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end

  always_comb begin
    for (int l = 0; l < L; l++) begin
      bd[l] = p2_v ? {16'(p2_a), 16'(l)} : (32'hDEAD0000 | 32'(l));
    end
  end

  assign buff_rdata = bd;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    logic [AW+36:0] o;
    o = {busy, done, buff_rd_en, buff_rd_addr,
         rd_tvalid, rd_tlast, rd_tdata};
    chk(name, longint'(o), 0);
  endtask

  int r_beats, r_reads, r_addr_bad, r_bad_data, r_bad_last;
  int r_unstable, r_done_cnt, r_busy_bad;
  int r_first, r_done, r_last;

  task automatic run_xfer(input int words, input int rmode,
                          input int re_at, input int re_words);
    int          eff;
    logic        held;
    logic [31:0] hold_d;
    logic        hold_l;
    logic [31:0] exp_d;
    eff = (words > L * D) ? L * D : words;
    r_beats = 0; r_reads = 0; r_addr_bad = 0;
    r_bad_data = 0; r_bad_last = 0; r_unstable = 0;
    r_done_cnt = 0; r_busy_bad = 0;
    r_first = -1; r_done = -1; r_last = -1;
    held = 1'b0; hold_d = '0; hold_l = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start      = (c == 0) || (c == re_at);
      xfer_words = (c == re_at) ? re_words : words;
      rd_tready  = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (buff_rd_en) begin
        if (buff_rd_addr != AW'(r_reads)) r_addr_bad++;
        r_reads++;
      end
      if (done) begin
        r_done_cnt++;
        if (r_done < 0) r_done = c;
      end
      if (busy !== (r_done < 0)) r_busy_bad++;
      if (held && (!rd_tvalid || rd_tdata != hold_d
                   || rd_tlast != hold_l)) r_unstable++;
      if (rd_tvalid && rd_tready) begin
        if (r_first < 0) r_first = c;
        exp_d = {16'(r_beats / L), 16'(r_beats % L)};
        if (rd_tdata != exp_d) r_bad_data++;
        if (rd_tlast != (r_beats == eff - 1)) r_bad_last++;
        if (rd_tlast) r_last = c;
        r_beats++;
      end
      held   = rd_tvalid && !rd_tready;
      hold_d = rd_tdata;
      hold_l = rd_tlast;
      if (r_done >= 0 && c >= r_done + 3) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    int words;
    int rmode;
    int beats;
    int reads;
    int first;
    int done_at;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nb;
    int stray;
    string t;

    tbl[0] = '{16,   0, 16,   2,   3,  19};
    tbl[1] = '{11,   0, 11,   2,   3,  14};
    tbl[2] = '{64,   1, 64,   8,  -1,  -1};
    tbl[3] = '{0,    0, 0,    0,  -1,   1};
    tbl[4] = '{1,    0, 1,    1,   3,   4};
    tbl[5] = '{8,    0, 8,    1,   3,  11};
    tbl[6] = '{9,    0, 9,    2,   3,  12};
    tbl[7] = '{2000, 0, 1024, 128, 3, 1027};
    tbl[8] = '{33,   1, 33,   5,  -1,  -1};
    tbl[9] = '{1024, 1, 1024, 128, -1, -1};

    rst = 1'b1; start = 1'b0; xfer_words = '0; rd_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset_outputs");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_xfer(tbl[i].words, tbl[i].rmode, -1, 0);
      t = $sformatf("v%0d_w%0d", i, tbl[i].words);
      chk({t, "_beats"},    r_beats,    tbl[i].beats);
      chk({t, "_reads"},    r_reads,    tbl[i].reads);
      chk({t, "_addr"},     r_addr_bad, 0);
      chk({t, "_data"},     r_bad_data, 0);
      chk({t, "_tlast"},    r_bad_last, 0);
      chk({t, "_stable"},   r_unstable, 0);
      chk({t, "_done_cnt"}, r_done_cnt, 1);
      chk({t, "_busy"},     r_busy_bad, 0);
      if (tbl[i].first >= 0)
        chk({t, "_first"}, r_first, tbl[i].first);
      if (tbl[i].done_at >= 0)
        chk({t, "_done_at"}, r_done, tbl[i].done_at);
      if (tbl[i].beats > 0)
        chk({t, "_done_lag"}, r_done - r_last, 1);
    end

    // Second start while busy must be ignored.
    run_xfer(16, 0, 4, 40);
    chk("restart_beats",    r_beats,    16);
    chk("restart_reads",    r_reads,    2);
    chk("restart_done_cnt", r_done_cnt, 1);
    chk("restart_done_at",  r_done,     19);
    chk("restart_data",     r_bad_data, 0);

    // Reset after beat 5 of a 32-word transfer.
    nb = 0;
    for (int c = 0; c < 50 && nb < 5; c++) begin
      @(negedge clk);
      start = (c == 0);
      xfer_words = 32;
      rd_tready = 1'b1;
      #1;
      if (rd_tvalid && rd_tready) nb++;
    end
    chk("rst_mid_beats", nb, 5);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk_idle("rst_mid_outputs");
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (rd_tvalid || done || busy) stray++;
    end
    chk("rst_mid_quiet", stray, 0);
    run_xfer(8, 0, -1, 0);
    chk("post_rst_beats",   r_beats,    8);
    chk("post_rst_reads",   r_reads,    1);
    chk("post_rst_data",    r_bad_data, 0);
    chk("post_rst_tlast",   r_bad_last, 0);
    chk("post_rst_done_at", r_done,     11);

    // Reset while row reads are in flight; late data must be dropped.
    @(negedge clk);
    start = 1'b1;
    xfer_words = 32;
    rd_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (rd_tvalid || done || busy || buff_rd_en) stray++;
    end
    chk("abort_inflight_quiet", stray, 0);
    chk_idle("abort_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/store_serializer.md
STORE_SERIALIZER -- requirements
Module: store_serializer

Interface
REQ-001 Parameter V_LANE_NUM, default 8; number of vector lanes and store-buffer banks.
REQ-002 Parameter BUFF_DEPTH, default 128; entries per lane store buffer.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32; stream data width, fixed at 32 in this revision.
REQ-004 Parameter C_XFER_SIZE_WIDTH, default 32; width of the word-count input.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a transfer.
REQ-009 xfer_words  input  C_XFER_SIZE_WIDTH  number of 32-bit words to send, sampled on start.
REQ-010 busy  output  1  high from the accepted start until the cycle done is asserted.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 buff_rd_en  output  1  read enable broadcast to all lane store buffers (enb and regceb).
REQ-013 buff_rd_addr  output  clog2(BUFF_DEPTH)  row address broadcast to all lanes.
REQ-014 buff_rdata  input  32 x V_LANE_NUM  per-lane buffer output, valid exactly 2 cycles after buff_rd_en.
REQ-015 rd_tvalid / rd_tready / rd_tlast / rd_tdata  output/input/output/output  1/1/1/32  AXI-stream toward the AXI master controller.

Function
REQ-016 Element k SHALL be read from lane (k mod V_LANE_NUM), row (k div V_LANE_NUM), and emitted in ascending k order.
REQ-017 start SHALL be accepted only when busy is low; a start received while busy is high SHALL be ignored.
REQ-018 States SHALL be IDLE, RUN and FLUSH; IDLE->RUN on accepted start with xfer_words>0; RUN->FLUSH when the last row read is issued; FLUSH->IDLE on the handshake of the final beat.
REQ-019 A start with xfer_words=0 SHALL produce done in the following cycle, with no reads and no beats; busy SHALL be high only during that intervening cycle.
REQ-020 Whole rows SHALL be prefetched into a 2-entry row FIFO (V_LANE_NUM x 32 bits per entry).
REQ-021 A read SHALL be issued only when (occupied entries + in-flight reads) < 2, counting in-flight reads over the 2-cycle latency.
REQ-022 Read addresses SHALL run 0..ceil(xfer_words/V_LANE_NUM)-1 with no wrap-around.
REQ-023 A lane index counter SHALL select rd_tdata from the head row.
REQ-024 The head row SHALL be popped on the handshake of lane V_LANE_NUM-1, or on the handshake of the final word of a partial last row.
REQ-025 rd_tvalid SHALL be high whenever the FIFO is non-empty in RUN or FLUSH.
REQ-026 rd_tdata and rd_tlast SHALL remain stable while rd_tvalid is high and rd_tready is low.
REQ-027 rd_tlast SHALL be high only on word xfer_words-1.
REQ-028 Steady-state throughput with rd_tready held high SHALL be 1 word per cycle after the initial 2-cycle fill latency.
REQ-029 A pop and a read-data arrival in the same cycle SHALL both take effect, leaving the FIFO count unchanged.
REQ-030 done SHALL pulse in the cycle after the final handshake, and busy SHALL fall in the same cycle that done is asserted.
REQ-031 xfer_words > BUFF_DEPTH*V_LANE_NUM is illegal; the design SHALL clamp the transfer to BUFF_DEPTH*V_LANE_NUM.

Reset
REQ-032 On rst, all outputs SHALL go to 0, the state SHALL be IDLE, and all counters and the FIFO SHALL be cleared.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer without done; read data that arrives after reset release SHALL be discarded.

Structure
REQ-034 Package vector_core_pkg SHALL hold VLMAX32, VLMAX32_PVL and BUFF_DEPTH derivations and the state enum.
REQ-035 The 2-entry row FIFO SHALL be a sub-module, row_fifo, with parameterised width and registered count.
REQ-036 The block SHALL instantiate no RAM; it drives the existing per-lane store buffer read ports.

Verification
REQ-037 V_LANE_NUM=8, xfer_words=16, lane l row r data = {r,l}, rd_tready=1 -> 16 beats in order, first beat 3 cycles after start, tlast on beat 16, done 1 cycle later.
REQ-038 xfer_words=11 -> rows 0 and 1 read; 11 beats; tlast on lane 2 of row 1; remaining lanes of row 1 never emitted.
REQ-039 rd_tready random 50% duty, xfer_words=64 -> data and tlast held stable under stall, no FIFO overflow, exactly 8 reads issued.
REQ-040 xfer_words=0 -> done 1 cycle after start, zero beats, buff_rd_en never asserted.
REQ-041 Second start while busy=1 -> ignored, xfer count unchanged, single done.
REQ-042 rst asserted after beat 5 of 32 -> all outputs 0 immediately; a new start with xfer_words=8 then completes cleanly.
